// File: rtl/mul3_arb_pkg.sv
// Shared types and constants for the three-operand multiplier arbiter.
// The state encoding, datapath widths and watchdog counter sizing live here
// so the arbiter and any future clients agree on them.
package mul3_arb_pkg;

    // Operand and product widths of the shared multiplicador3 core.
    localparam int OP_W  = 32;
    localparam int RES_W = 64;

    // Sequencer phases: wait for a request, run the multiplier, acknowledge
    // its result, hand the result back to the requester.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // The watchdog counter must be able to hold TIMEOUT itself, because it
    // is incremented once more in the cycle that detects TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
// Selects the first asserted request at or above 'ptr', wrapping modulo N.
// Instead of rotating the request vector, each requester is given its
// distance from the pointer and the nearest asserted one wins; distances
// are unique, so the result is one-hot by construction.
module rr_picker #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             any
);

    int best;

    // Find the smallest pointer distance among asserted requests, then mark
    // the single requester sitting at that distance.
    always_comb begin
        best = N;
        pick = '0;
        any  = |req;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (((i + N - int'(ptr)) % N) < best)) begin
                best = (i + N - int'(ptr)) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            pick[i] = req[i] && (((i + N - int'(ptr)) % N) == best);
        end
    end

endmodule

// File: rtl/mul3_arbiter.sv
// Round-robin arbiter and sequencer sharing one multiplicador3 core among
// N requesters. The winner's operands are latched in its grant cycle, the
// multiplier's valid/ack handshake is driven here, and the 64-bit product
// (or a timeout error) is returned with a one-hot response pulse.
module mul3_arbiter
    import mul3_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*OP_W-1:0]   a_in,
    input  logic [N*OP_W-1:0]   b_in,
    input  logic [N*OP_W-1:0]   c_in,
    output logic [N-1:0]        grant,
    output logic [N-1:0]        resp_valid,
    output logic [RES_W-1:0]    resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic [OP_W-1:0]     mul_a,
    output logic [OP_W-1:0]     mul_b,
    output logic [OP_W-1:0]     mul_c,
    output logic                mul_valid_data,
    output logic                mul_ack,
    input  logic [RES_W-1:0]    mul_producto,
    input  logic                mul_done_flag
);

    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id;
    logic [ID_W-1:0]   pick_id;
    logic [CNT_W-1:0]  cnt;
    logic [RES_W-1:0]  result;
    logic              err;
    logic [N-1:0]      pick;
    logic              any_req;
    logic              take;
    logic              timeout_hit;
    logic [OP_W-1:0]   a_sel;
    logic [OP_W-1:0]   b_sel;
    logic [OP_W-1:0]   c_sel;

    rr_picker #(
        .N     (N),
        .PTR_W (ID_W)
    ) u_picker (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any_req)
    );

    // A request is accepted only from IDLE, and never while a stale
    // multiplier result is still waiting to be acknowledged. Reset gates it
    // so that every output reads zero for as long as reset is held.
    assign take        = (state == ST_IDLE) && !reset && !mul_done_flag && any_req;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign grant       = take ? pick : '0;

    // Turn the one-hot pick into a requester index and route that
    // requester's operand slice towards the operand registers.
    always_comb begin
        pick_id = '0;
        a_sel   = '0;
        b_sel   = '0;
        c_sel   = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                pick_id = ID_W'(i);
                a_sel   = a_in[i*OP_W +: OP_W];
                b_sel   = b_in[i*OP_W +: OP_W];
                c_sel   = c_in[i*OP_W +: OP_W];
            end
        end
    end

    // Sequencer transitions; a done flag seen in ISSUE beats the watchdog
    // firing in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mul_done_flag) begin
                    state_next = ST_ACK;
                end else if (timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_ACK: begin
                if (!mul_done_flag) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch at grant, watchdog counting, result capture and
    // round-robin pointer advance once the response has been delivered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a  <= '0;
            mul_b  <= '0;
            mul_c  <= '0;
            id     <= '0;
            ptr    <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        mul_a <= a_sel;
                        mul_b <= b_sel;
                        mul_c <= c_sel;
                        id    <= pick_id;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (mul_done_flag) begin
                        result <= mul_producto;
                        err    <= 1'b0;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (id == ID_W'(N - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= id + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and response outputs are decoded from the current state.
    // In IDLE a raised done flag can only be a leftover from a timed-out
    // transaction, so it is acknowledged to flush it.
    always_comb begin
        busy           = (state != ST_IDLE);
        mul_valid_data = (state == ST_ISSUE);
        mul_ack        = (state == ST_ACK) ||
                         ((state == ST_IDLE) && mul_done_flag && !reset);
        resp_valid     = '0;
        resp_data      = '0;
        resp_err       = 1'b0;
        if (state == ST_RESP) begin
            for (int i = 0; i < N; i++) begin
                resp_valid[i] = (id == ID_W'(i));
            end
            resp_data = result;
            resp_err  = err;
        end
    end

endmodule

// File: tb/tb_mul3_arbiter.sv
// Self-checking bench for mul3_arbiter with a behavioural multiplicador3
// model (random latency, optional silence for the watchdog, injectable
// stale result). Expected grants come from a round-robin reference that
// tracks the last served requester; expected results are a*b*c.
module tb_mul3_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*32-1:0] a_in;
    logic [N*32-1:0] b_in;
    logic [N*32-1:0] c_in;
    logic [N-1:0]    grant;
    logic [N-1:0]    resp_valid;
    logic [63:0]     resp_data;
    logic            resp_err;
    logic            busy;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [31:0]     mul_c;
    logic            mul_valid_data;
    logic            mul_ack;
    logic [63:0]     mul_producto;
    logic            mul_done_flag;

    int   total = 0;
    int   bad   = 0;
    int   last_id;
    logic mdl_enable;
    logic inject;
    int   mdl_lat;
    int   mdl_cnt;

    mul3_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .a_in           (a_in),
        .b_in           (b_in),
        .c_in           (c_in),
        .grant          (grant),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .busy           (busy),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_c          (mul_c),
        .mul_valid_data (mul_valid_data),
        .mul_ack        (mul_ack),
        .mul_producto   (mul_producto),
        .mul_done_flag  (mul_done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] prod3(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        p = p * 64'(c);
        return p;
    endfunction

    // Reference round-robin: first asserted requester after the last one served.
    function automatic int nextGrant(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Multiplier model: after valid_data has been seen for mdl_lat+1 edges it
    // raises done with the product, then holds it until acknowledged.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_done_flag <= 1'b0;
            mul_producto  <= '0;
            mdl_cnt       <= 0;
        end else if (inject) begin
            mul_done_flag <= 1'b1;
            mul_producto  <= 64'hDEAD_BEEF_0BAD_F00D;
        end else if (mul_done_flag) begin
            if (mul_ack) mul_done_flag <= 1'b0;
        end else if (mul_valid_data && mdl_enable) begin
            if (mdl_cnt >= mdl_lat) begin
                mul_done_flag <= 1'b1;
                mul_producto  <= prod3(mul_a, mul_b, mul_c);
                mdl_cnt       <= 0;
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end else begin
            mdl_cnt <= 0;
        end
    end

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expireBound(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s observed=no_event expected=event_within_bound", tag);
    endtask

    task automatic applyStimulus(input logic [N-1:0] r);
        req = r;
        #1;
    endtask

    task automatic setSlice(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c);
        a_in[i*32 +: 32] = a;
        b_in[i*32 +: 32] = b;
        c_in[i*32 +: 32] = c;
    endtask

    task automatic waitGrant(input string tag, output logic [N-1:0] g);
        int waited;
        waited = 0;
        while (grant == '0 && waited < 40) begin
            nextCycle();
            waited++;
        end
        if (grant == '0) expireBound({tag, "_grant_wait"});
        g = grant;
    endtask

    task automatic waitResp(input string tag, output logic [N-1:0] rv,
                            output logic [63:0] d, output logic er);
        int waited;
        waited = 0;
        while (resp_valid == '0 && waited < 40) begin
            nextCycle();
            waited++;
        end
        if (resp_valid == '0) expireBound({tag, "_resp_wait"});
        rv = resp_valid;
        d  = resp_data;
        er = resp_err;
    endtask

    // One complete transaction: predict and check the grant, check the
    // issued operands, optionally release/add requests and scramble the
    // served slice, then check the response against the captured operands.
    task automatic serve(input string tag, input logic drop, input logic [N-1:0] add_mask,
                         output int served_id, output logic [63:0] data_seen);
        logic [N-1:0] g;
        logic [N-1:0] rv;
        logic [N-1:0] exp_mask;
        logic [63:0]  d;
        logic         er;
        logic [31:0]  ea;
        logic [31:0]  eb;
        logic [31:0]  ec;
        int           e;
        mdl_lat = int'($urandom_range(0, 4));
        waitGrant(tag, g);
        e = nextGrant(req, last_id);
        exp_mask = '0;
        if (e >= 0) exp_mask[e] = 1'b1;
        checkOutput({tag, "_grant"}, 64'(g), 64'(exp_mask));
        if (e < 0) e = 0;
        ea = a_in[e*32 +: 32];
        eb = b_in[e*32 +: 32];
        ec = c_in[e*32 +: 32];
        last_id = e;
        nextCycle();
        checkOutput({tag, "_issue_valid"}, 64'(mul_valid_data), 64'(1'b1));
        checkOutput({tag, "_mul_a"}, 64'(mul_a), 64'(ea));
        checkOutput({tag, "_mul_c"}, 64'(mul_c), 64'(ec));
        if (drop) req[e] = 1'b0;
        req = req | add_mask;
        setSlice(e, $urandom, $urandom, $urandom);
        waitResp(tag, rv, d, er);
        checkOutput({tag, "_resp_valid"}, 64'(rv), 64'(exp_mask));
        checkOutput({tag, "_resp_data"}, d, prod3(ea, eb, ec));
        checkOutput({tag, "_resp_err"}, 64'(er), 64'(1'b0));
        served_id = e;
        data_seen = d;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_watchdog observed=still_running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] rv;
        logic [N-1:0] exp_mask;
        logic [63:0]  d;
        logic         er;
        int           sid;
        int           e;
        int           cycles;

        reset      = 1'b0;
        req        = '0;
        a_in       = '0;
        b_in       = '0;
        c_in       = '0;
        mdl_enable = 1'b1;
        inject     = 1'b0;
        mdl_lat    = 0;
        last_id    = N - 1;
        #2 reset = 1'b1;
        #1;

        // Reset values.
        checkOutput("rst_grant", 64'(grant), 64'(0));
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_valid_data", 64'(mul_valid_data), 64'(0));
        checkOutput("rst_ack", 64'(mul_ack), 64'(0));
        checkOutput("rst_mul_a", 64'(mul_a), 64'(0));
        checkOutput("rst_resp_data", resp_data, 64'(0));
        checkOutput("rst_resp_err", 64'(resp_err), 64'(0));
        nextCycle();
        nextCycle();
        reset = 1'b0;
        nextCycle();

        // Single request: grant in the same IDLE cycle, 4*3*2 back.
        setSlice(0, 32'd4, 32'd3, 32'd2);
        applyStimulus(4'b0001);
        checkOutput("single_grant_now", 64'(grant), 64'(4'b0001));
        serve("single", 1'b1, '0, sid, d);
        checkOutput("single_result", d, 64'd24);
        applyStimulus('0);
        nextCycle();

        // All four from reset: order 0,1,2,3 with results 6,12,18,24.
        reset = 1'b1;
        nextCycle();
        reset   = 1'b0;
        last_id = N - 1;
        for (int i = 0; i < N; i++) setSlice(i, 32'(i + 1), 32'd2, 32'd3);
        applyStimulus(4'b1111);
        for (int k = 0; k < N; k++) begin
            serve("all4", 1'b1, '0, sid, d);
            checkOutput("all4_order", 64'(sid), 64'(k));
            checkOutput("all4_result", d, 64'((k + 1) * 6));
        end
        applyStimulus('0);
        nextCycle();

        // Fairness: 0 held, 2 arrives during transaction 0 -> order 0,2,0.
        setSlice(0, 32'd5, 32'd7, 32'd11);
        setSlice(2, 32'd13, 32'd17, 32'd19);
        applyStimulus(4'b0001);
        serve("fair_t0", 1'b0, 4'b0100, sid, d);
        checkOutput("fair_first", 64'(sid), 64'(0));
        serve("fair_t1", 1'b1, '0, sid, d);
        checkOutput("fair_second", 64'(sid), 64'(2));
        serve("fair_t2", 1'b1, '0, sid, d);
        checkOutput("fair_third", 64'(sid), 64'(0));
        applyStimulus('0);
        nextCycle();

        // Random request patterns and operands against the reference.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) setSlice(i, $urandom, $urandom, $urandom);
            req = req | N'($urandom);
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            #1;
            serve("rand", 1'b1, N'($urandom), sid, d);
        end
        applyStimulus('0);
        nextCycle();
        nextCycle();

        // Timeout: silent multiplier, error response TIMEOUT+1 cycles after grant.
        mdl_enable = 1'b0;
        applyStimulus(4'b0010);
        waitGrant("timeout", g);
        e = nextGrant(req, last_id);
        exp_mask = '0;
        if (e >= 0) exp_mask[e] = 1'b1;
        checkOutput("timeout_grant", 64'(g), 64'(exp_mask));
        if (e >= 0) last_id = e;
        nextCycle();
        cycles = 1;
        req = '0;
        while (resp_valid == '0 && cycles < 40) begin
            nextCycle();
            cycles++;
        end
        if (resp_valid == '0) begin
            expireBound("timeout_resp_wait");
        end else begin
            checkOutput("timeout_latency", 64'(cycles), 64'(TIMEOUT + 1));
            checkOutput("timeout_resp_valid", 64'(resp_valid), 64'(exp_mask));
            checkOutput("timeout_err", 64'(resp_err), 64'(1'b1));
            checkOutput("timeout_data", resp_data, 64'(0));
        end
        nextCycle();

        // Late done after the timeout is acked in IDLE before a new grant.
        inject = 1'b1;
        nextCycle();
        inject = 1'b0;
        applyStimulus(4'b0100);
        checkOutput("stale_no_grant", 64'(grant), 64'(0));
        checkOutput("stale_ack", 64'(mul_ack), 64'(1'b1));
        nextCycle();
        e = nextGrant(req, last_id);
        exp_mask = '0;
        if (e >= 0) exp_mask[e] = 1'b1;
        checkOutput("stale_then_grant", 64'(grant), 64'(exp_mask));
        mdl_enable = 1'b1;
        setSlice(2, 32'd9, 32'd10, 32'd3);
        #1;
        serve("stale_follow", 1'b1, '0, sid, d);
        applyStimulus('0);
        nextCycle();

        // Reset three cycles into ISSUE: outputs clear at once, no response.
        mdl_enable = 1'b0;
        applyStimulus(4'b1000);
        waitGrant("midrst", g);
        e = nextGrant(req, last_id);
        exp_mask = '0;
        if (e >= 0) exp_mask[e] = 1'b1;
        checkOutput("midrst_grant", 64'(g), 64'(exp_mask));
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("midrst_busy_before", 64'(busy), 64'(1'b1));
        reset = 1'b1;
        #1;
        checkOutput("midrst_grant_zero", 64'(grant), 64'(0));
        checkOutput("midrst_busy_zero", 64'(busy), 64'(0));
        checkOutput("midrst_valid_zero", 64'(mul_valid_data), 64'(0));
        checkOutput("midrst_ack_zero", 64'(mul_ack), 64'(0));
        checkOutput("midrst_mul_a_zero", 64'(mul_a), 64'(0));
        checkOutput("midrst_resp_zero", 64'(resp_valid), 64'(0));
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            checkOutput("midrst_no_resp", 64'(resp_valid), 64'(0));
        end

        // After reset the pointer is back at 0: all-request pick is slice 0.
        setSlice(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        for (int i = 1; i < N; i++) setSlice(i, $urandom, $urandom, $urandom);
        req        = 4'b1111;
        mdl_enable = 1'b1;
        last_id    = N - 1;
        reset      = 1'b0;
        #1;
        serve("post_rst", 1'b1, '0, sid, d);
        checkOutput("post_rst_id", 64'(sid), 64'(0));
        checkOutput("post_rst_result", d, 64'hFFFF_FFFE_0000_0001);
        applyStimulus('0);
        nextCycle();
        nextCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul3_arbiter.md
# mul3_arbiter

Round-robin arbiter and sequencer that shares one `multiplicador3` three-operand multiplier among `N` requesters. It sits between the client blocks and the multiplier. It latches one requester's `a`, `b`, `c` at grant and drives the multiplier's `valid_data`/`ack` handshake. It captures `producto` and returns the result, tagged by a one-hot response pulse. A watchdog aborts a transaction if `Done_Flag` never arrives.

## Interface
- `N`, 4: number of requesters (2–8).
- `TIMEOUT`, 64: max cycles in ISSUE waiting for `Done_Flag` before abort (≥2).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in N: per-requester request level.
- `a_in`, `b_in`, `c_in` in N*32 each: flattened operands; slice i is bits [32i+31:32i].
- `grant` out N: one-hot, one-cycle pulse when a request is accepted and its operands are latched.
- `resp_valid` out N: one-hot, one-cycle pulse carrying the result back to the granted requester.
- `resp_data` out 64: result, valid only during the `resp_valid` pulse.
- `resp_err` out 1: timeout flag, valid only during the `resp_valid` pulse.
- `busy` out 1: high in any state except IDLE.
- `mul_a`, `mul_b`, `mul_c` out 32 each: registered operands to the multiplier.
- `mul_valid_data` out 1: multiplier start/valid.
- `mul_ack` out 1: result acknowledge to the multiplier.
- `mul_producto` in 64: multiplier result.
- `mul_done_flag` in 1: multiplier done.

## Operation
- States: IDLE, ISSUE, ACK, RESP.
- IDLE:
  - If `mul_done_flag`=1 (stale result): drive `mul_ack`=1, issue no grant, stay in IDLE.
  - Otherwise, if any `req` bit is set: pick the first set bit searching upward from `ptr`, wrapping modulo N.
  - On a pick: latch that slice's operands into `mul_a/b/c`, store `id`, pulse `grant[id]`, clear the timeout counter, go to ISSUE.
- ISSUE:
  - `mul_valid_data`=1; the counter increments each cycle.
  - If `mul_done_flag`=1: capture `mul_producto` into the result register and go to ACK. This takes priority over timeout in the same cycle.
  - Else if the counter reaches `TIMEOUT-1`: set the err flag, set result to 0, go to RESP.
- ACK: `mul_valid_data`=0, `mul_ack`=1. Hold until `mul_done_flag`=0, then go to RESP.
- RESP:
  - Pulse `resp_valid[id]` with `resp_data`=result and `resp_err`=err.
  - Update `ptr`=(id+1) mod N and go to IDLE.
- Operands are sampled only in the grant cycle. The requester may drop `req` or change its operands afterwards.
- A `req` that is still high after its own `resp_valid` is treated as a new request.
- `req` bits that drop while not yet granted are simply not served.
- Full 64-bit product is passed through unmodified; the arbiter does no arithmetic.

## Timing
- Reset values: all outputs 0, state IDLE, `ptr`=0, counter 0, result 0, err 0.
- Grant latency: `grant` is asserted in the first IDLE cycle in which `req`≠0 and `mul_done_flag`=0. `mul_valid_data` rises the next cycle.
- `resp_valid` comes 1 cycle after ACK exits, i.e. 1 cycle after `mul_done_flag` is seen low.
- Timeout path: `resp_valid` with `resp_err`=1 occurs exactly `TIMEOUT`+1 cycles after `grant`.
- Minimum spacing between grants is 4 cycles (IDLE, ISSUE, ACK, RESP).
- Simultaneous requests: only one grant per transaction. Round-robin guarantees each active requester is served within N transactions.
- Reset mid-transaction: everything returns to reset values asynchronously and no `resp_valid` is emitted. The multiplier shares `reset`, so no cleanup is needed.
- A late `Done_Flag` after a timeout is flushed by the IDLE stale-ack rule before the next grant.

## Structure
- Package `mul3_arb_pkg`:
  - state enum (IDLE, ISSUE, ACK, RESP);
  - localparams `OP_W`=32 and `RES_W`=64;
  - counter width `$clog2(TIMEOUT+1)`.
- Sub-module `rr_picker`: combinational round-robin priority encoder with inputs `req[N]` and `ptr`, outputs one-hot `pick` and `any`.
- FSM, operand/result registers and watchdog live in `mul3_arbiter`.

## Test plan
- Single request:
  - Stimulus: `req`=0001, slice0 = (4, 3, 2), multiplier model present.
  - Required: `grant`=0001; `mul_valid_data` high until `Done_Flag`; `resp_valid`=0001, `resp_data`=24, `resp_err`=0.
- All four requesting from reset:
  - Stimulus: `req`=1111, slices i = (i+1, 2, 3).
  - Required: grant order 0, 1, 2, 3; results 6, 12, 18, 24.
- Round-robin fairness:
  - Stimulus: requester 0 held high continuously, requester 2 asserted during transaction 0.
  - Required: transaction order 0, 2, 0.
- Timeout:
  - Stimulus: multiplier model never raises `Done_Flag`, `TIMEOUT`=8.
  - Required: `resp_err`=1 and `resp_data`=0 exactly 9 cycles after `grant`.
  - Follow-up: a late `Done_Flag` is acked in IDLE and the next grant waits for it to drop.
- Reset mid-ISSUE:
  - Stimulus: assert `reset` 3 cycles after a grant.
  - Required: all outputs 0 at once, no `resp_valid`, `ptr`=0.
  - Follow-up: a new request with (0xFFFFFFFF, 0xFFFFFFFF, 1) returns 0xFFFFFFFE00000001.
